// File: rtl/spi_seq_pkg.sv
// Shared definitions for the SPI command sequencer.
//   WORD_W / BITS_W / OP_W : data word, engine bit-count and opcode widths
//   OP_*                   : command opcodes carried on cmd_op
//   seq_state_e            : sequencer state encoding
//   bits_mask()            : mask of the valid received bits for an engine bits-1 code
package spi_seq_pkg;

  localparam int WORD_W = 16;
  localparam int BITS_W = 4;
  localparam int OP_W   = 2;

  localparam logic [OP_W-1:0] OP_CS_LOW  = 2'd0;
  localparam logic [OP_W-1:0] OP_CS_HIGH = 2'd1;
  localparam logic [OP_W-1:0] OP_XFER    = 2'd2;
  localparam logic [OP_W-1:0] OP_DELAY   = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_GO        = 3'd1,
    ST_WAIT_BUSY = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_DELAY     = 3'd4
  } seq_state_e;

  // bits is the engine's bits-1 code, so code 7 keeps the low 8 bits
  function automatic logic [WORD_W-1:0] bits_mask(input logic [BITS_W-1:0] bits);
    logic [WORD_W-1:0] ones;
    ones = '1;
    return ones >> (4'd15 - bits);
  endfunction

endpackage

// File: rtl/spi_cmd_sequencer_if.sv
// Command and response handshake bundle between the host/command FIFO and the sequencer.
//   cmd_valid/cmd_ready/cmd_op/cmd_data/cmd_bits : command port (host -> sequencer)
//   rsp_valid/rsp_ready/rsp_data                  : single-entry response port (sequencer -> host)
// Modports: master = host side, slave = sequencer side.
interface spi_cmd_sequencer_if;
  import spi_seq_pkg::*;

  logic              cmd_valid;
  logic              cmd_ready;
  logic [OP_W-1:0]   cmd_op;
  logic [WORD_W-1:0] cmd_data;
  logic [BITS_W-1:0] cmd_bits;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [WORD_W-1:0] rsp_data;

  modport master (
    output cmd_valid, cmd_op, cmd_data, cmd_bits, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_data, cmd_bits, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data
  );

endinterface

// File: rtl/spi_seq_timer.sv
// Loadable down-counter with zero flag, shared by DELAY and the engine timeout.
//   clkin, rst : clock and synchronous active-high reset
//   load       : load load_val (wins over dec)
//   load_val   : value to load
//   dec        : decrement by one, saturating at zero
//   zero       : counter is zero
module spi_seq_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clkin,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_r;

  // Count register: load has priority, decrement stops at zero
  always_ff @(posedge clkin) begin
    if (rst) begin
      cnt_r <= '0;
    end else if (load) begin
      cnt_r <= load_val;
    end else if (dec && (cnt_r != '0)) begin
      cnt_r <= cnt_r - CNT_W'(1'b1);
    end
  end

  assign zero = (cnt_r == '0);

endmodule

// File: rtl/spi_cmd_sequencer.sv
// Command-driven controller in front of the sio SPI master engine. Executes CS_LOW, CS_HIGH,
// XFER and DELAY opcodes, owns chip select, pulses the engine's go and returns each received
// word on a single-entry response port.
//   clkin, rst      : clock and synchronous active-high reset (engine shares rst)
//   host            : command/response handshake bundle (slave side)
//   busy            : sequencer not idle
//   err_timeout     : sticky engine-timeout flag
//   eng_go/eng_data_i/eng_bits/eng_autocs : to engine
//   eng_state/eng_data_o                  : from engine
//   cs              : chip select pin, active low
// Optional feature: define SEQ_TIMEOUT_EN to abort an XFER when the engine has not returned
// to idle TIMEOUT_CYC cycles after go; otherwise err_timeout is tied low and waits are unbounded.
module spi_cmd_sequencer
  import spi_seq_pkg::*;
#(
  parameter int DELAY_W     = 8,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                clkin,
  input  logic                rst,
  spi_cmd_sequencer_if.slave  host,
  output logic                busy,
  output logic                err_timeout,
  output logic                eng_go,
  input  logic                eng_state,
  output logic [WORD_W-1:0]   eng_data_i,
  input  logic [WORD_W-1:0]   eng_data_o,
  output logic [BITS_W-1:0]   eng_bits,
  output logic                eng_autocs,
  output logic                cs
);

  localparam int TO_W  = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int CNT_W = (DELAY_W > TO_W) ? DELAY_W : TO_W;

  seq_state_e        state_r, state_s;
  logic              cmd_ready_s, accept_s;
  logic              xfer_go_s, cs_low_s, cs_high_s, capture_s, abort_s, timeout_s;
  logic              tmr_load_s, tmr_dec_s, tmr_zero_s;
  logic [CNT_W-1:0]  tmr_val_s, delay_n_s;
  logic              delay_zero_s;
  logic              cs_r, eng_go_r, rsp_valid_r;
  logic [WORD_W-1:0] eng_data_i_r, rsp_data_r;
  logic [BITS_W-1:0] eng_bits_r;

  // A held response blocks new commands so it can never be overwritten
  assign cmd_ready_s    = !rst && (state_r == ST_IDLE) && !rsp_valid_r;
  assign accept_s       = host.cmd_valid && cmd_ready_s;
  assign delay_n_s      = CNT_W'(host.cmd_data[DELAY_W-1:0]);
  assign delay_zero_s   = (delay_n_s == '0);

  assign host.cmd_ready = cmd_ready_s;
  assign host.rsp_valid = rsp_valid_r;
  assign host.rsp_data  = rsp_data_r;
  assign busy           = (state_r != ST_IDLE);
  assign eng_go         = eng_go_r;
  assign eng_data_i     = eng_data_i_r;
  assign eng_bits       = eng_bits_r;
  assign eng_autocs     = 1'b0;
  assign cs             = cs_r;

`ifdef SEQ_TIMEOUT_EN
  assign timeout_s = tmr_zero_s &&
                     ((state_r == ST_GO) || (state_r == ST_WAIT_BUSY) || (state_r == ST_WAIT_DONE));
`else
  assign timeout_s = 1'b0;
`endif

  spi_seq_timer #(.CNT_W(CNT_W)) u_timer (
    .clkin    (clkin),
    .rst      (rst),
    .load     (tmr_load_s),
    .load_val (tmr_val_s),
    .dec      (tmr_dec_s),
    .zero     (tmr_zero_s)
  );

  // State register
  always_ff @(posedge clkin) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s && (host.cmd_op == OP_XFER)) begin
          state_s = ST_GO;
        end else if (accept_s && (host.cmd_op == OP_DELAY) && !delay_zero_s) begin
          state_s = ST_DELAY;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_GO: begin
        state_s = timeout_s ? ST_IDLE : ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        if (eng_state) begin
          state_s = ST_WAIT_DONE;
        end else if (timeout_s) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_WAIT_BUSY;
        end
      end
      ST_WAIT_DONE: begin
        state_s = (!eng_state || timeout_s) ? ST_IDLE : ST_WAIT_DONE;
      end
      ST_DELAY: begin
        state_s = tmr_zero_s ? ST_IDLE : ST_DELAY;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Per-state control strobes
  always_comb begin
    xfer_go_s  = 1'b0;
    cs_low_s   = 1'b0;
    cs_high_s  = 1'b0;
    capture_s  = 1'b0;
    abort_s    = 1'b0;
    tmr_load_s = 1'b0;
    tmr_val_s  = '0;
    tmr_dec_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          case (host.cmd_op)
            OP_CS_LOW:  cs_low_s  = 1'b1;
            OP_CS_HIGH: cs_high_s = 1'b1;
            OP_XFER: begin
              xfer_go_s = 1'b1;
`ifdef SEQ_TIMEOUT_EN
              tmr_load_s = 1'b1;
              tmr_val_s  = CNT_W'(TIMEOUT_CYC - 1);
`endif
            end
            OP_DELAY: begin
              // Loading n-1 and leaving on zero keeps the block busy exactly n cycles
              tmr_load_s = !delay_zero_s;
              tmr_val_s  = delay_n_s - CNT_W'(1'b1);
            end
            default: begin
              xfer_go_s = 1'b0;
            end
          endcase
        end else begin
          tmr_load_s = 1'b0;
        end
      end
      ST_GO: begin
        tmr_dec_s = 1'b1;
        abort_s   = timeout_s;
      end
      ST_WAIT_BUSY: begin
        tmr_dec_s = 1'b1;
        abort_s   = timeout_s && !eng_state;
      end
      ST_WAIT_DONE: begin
        tmr_dec_s = 1'b1;
        capture_s = !eng_state;
        abort_s   = timeout_s && eng_state;
      end
      ST_DELAY: begin
        tmr_dec_s = 1'b1;
      end
      default: begin
        tmr_dec_s = 1'b0;
      end
    endcase
  end

  // Registered outputs: chip select, engine request and response holding register
  always_ff @(posedge clkin) begin
    if (rst) begin
      cs_r         <= 1'b1;
      eng_go_r     <= 1'b0;
      eng_data_i_r <= '0;
      eng_bits_r   <= '0;
      rsp_valid_r  <= 1'b0;
      rsp_data_r   <= '0;
    end else begin
      eng_go_r <= xfer_go_s;
      if (xfer_go_s) begin
        eng_data_i_r <= host.cmd_data;
        eng_bits_r   <= host.cmd_bits;
      end
      if (cs_low_s) begin
        cs_r <= 1'b0;
      end else if (cs_high_s || abort_s) begin
        cs_r <= 1'b1;
      end
      if (capture_s) begin
        rsp_valid_r <= 1'b1;
        rsp_data_r  <= eng_data_o & bits_mask(eng_bits_r);
      end else if (rsp_valid_r && host.rsp_ready) begin
        rsp_valid_r <= 1'b0;
      end
    end
  end

`ifdef SEQ_TIMEOUT_EN
  logic err_timeout_r;

  // Sticky timeout flag, cleared only by reset
  always_ff @(posedge clkin) begin
    if (rst) begin
      err_timeout_r <= 1'b0;
    end else if (abort_s) begin
      err_timeout_r <= 1'b1;
    end
  end

  assign err_timeout = err_timeout_r;
`else
  assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_spi_cmd_sequencer.sv
// Self-checking bench for spi_cmd_sequencer: directed scenarios plus randomized command
// stream against a behavioural model of the expected cs, response words and busy durations.
module tb_spi_cmd_sequencer;
  import spi_seq_pkg::*;

  localparam int TIMEOUT_CYC = 64;

  logic        clkin = 1'b0;
  logic        rst;
  logic        busy, err_timeout, eng_go, eng_state, eng_autocs, cs;
  logic [15:0] eng_data_i, eng_data_o;
  logic [3:0]  eng_bits;

  spi_cmd_sequencer_if host();

  spi_cmd_sequencer dut (
    .clkin       (clkin),
    .rst         (rst),
    .host        (host),
    .busy        (busy),
    .err_timeout (err_timeout),
    .eng_go      (eng_go),
    .eng_state   (eng_state),
    .eng_data_i  (eng_data_i),
    .eng_data_o  (eng_data_o),
    .eng_bits    (eng_bits),
    .eng_autocs  (eng_autocs),
    .cs          (cs)
  );

  always #5 clkin = ~clkin;

  int   n_checks = 0;
  int   n_bad    = 0;
  int   go_cnt   = 0;
  int   eng_mode = 0;   // 0: mosi looped to miso, 1: miso held high, 2: engine never starts
  int   eng_lat  = 0;
  logic exp_cs   = 1'b1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] low_mask(input logic [3:0] b);
    logic [15:0] m;
    m = 16'h0000;
    for (int i = 0; i < 16; i++) begin
      if (i <= int'(b)) m[i] = 1'b1;
    end
    return m;
  endfunction

  // Count cycles with eng_go high
  always @(negedge clkin) if (eng_go) go_cnt++;

  // Engine model: after go, waits eng_lat cycles, is busy for bits+1 cycles, then presents data
  initial begin : engine_model
    int          phase, cnt;
    logic [15:0] d;
    logic [3:0]  b;
    phase = 0; cnt = 0; d = 16'h0000; b = 4'h0;
    eng_state = 1'b0; eng_data_o = 16'h0000;
    forever begin
      @(negedge clkin);
      if (rst) begin
        phase = 0; eng_state = 1'b0;
      end else begin
        case (phase)
          0: if (eng_go && eng_mode != 2) begin
               d = eng_data_i; b = eng_bits; cnt = eng_lat; phase = 1;
             end
          1: if (cnt == 0) begin
               eng_state = 1'b1; cnt = int'(b) + 1; phase = 2;
             end else cnt--;
          2: begin
               cnt--;
               if (cnt == 0) begin
                 // loopback puts junk above the transferred bits; sequencer must clear it
                 eng_data_o = (eng_mode == 1) ? 16'hFFFF
                            : ((d & low_mask(b)) | (16'($urandom) & ~low_mask(b)));
                 eng_state = 1'b0; phase = 0;
               end
             end
          default: phase = 0;
        endcase
      end
    end
  end

  // Offer a command at a negedge; returns at the negedge after the accepting edge
  task automatic send(input logic [1:0] op, input logic [15:0] data, input logic [3:0] bits);
    int w;
    host.cmd_op = op; host.cmd_data = data; host.cmd_bits = bits; host.cmd_valid = 1'b1;
    w = 0;
    while (!host.cmd_ready && w < 300) begin
      @(negedge clkin); w++;
    end
    check_eq("cmd_accept_in_time", 32'(w < 300), 32'd1);
    @(negedge clkin);
    host.cmd_valid = 1'b0;
    if (op == OP_CS_LOW) exp_cs = 1'b0;
    else if (op == OP_CS_HIGH) exp_cs = 1'b1;
  endtask

  task automatic do_xfer(input logic [15:0] data, input logic [3:0] bits, input int mode, input int hold);
    int          g0, w;
    logic        cs_ok;
    logic [15:0] exp, held;
    eng_mode = mode;
    eng_lat  = $urandom_range(0, 2);
    g0 = go_cnt;
    send(OP_XFER, data, bits);
    exp = (mode == 1) ? low_mask(bits) : (data & low_mask(bits));
    cs_ok = 1'b1; w = 0;
    while (!host.rsp_valid && w < 300) begin
      if (cs !== exp_cs) cs_ok = 1'b0;
      @(negedge clkin); w++;
    end
    check_eq("rsp_in_time", 32'(w < 300), 32'd1);
    check_eq("cs_during_xfer", 32'(cs_ok), 32'd1);
    check_eq("cs_after_xfer", 32'(cs), 32'(exp_cs));
    check_eq("rsp_data", 32'(host.rsp_data), 32'(exp));
    check_eq("busy_at_rsp", 32'(busy), 32'd0);
    check_eq("go_pulses", 32'(go_cnt - g0), 32'd1);
    if (hold > 0) begin
      held = host.rsp_data;
      host.cmd_op = OP_XFER; host.cmd_data = 16'($urandom); host.cmd_bits = 4'hF;
      host.cmd_valid = 1'b1;
      for (int i = 0; i < hold; i++) begin
        check_eq("ready_while_rsp_held", 32'(host.cmd_ready), 32'd0);
        check_eq("rsp_stable", 32'(host.rsp_data), 32'(held));
        @(negedge clkin);
      end
      host.cmd_valid = 1'b0;
      check_eq("no_accept_while_held", 32'(busy), 32'd0);
    end
    host.rsp_ready = 1'b1;
    @(negedge clkin);
    host.rsp_ready = 1'b0;
    check_eq("rsp_cleared", 32'(host.rsp_valid), 32'd0);
    check_eq("ready_after_pop", 32'(host.cmd_ready), 32'd1);
  endtask

  task automatic do_delay(input int n);
    int cnt;
    send(OP_DELAY, {8'($urandom), 8'(n)}, 4'($urandom));
    cnt = 0;
    while (busy && cnt < 400) begin
      cnt++; @(negedge clkin);
    end
    check_eq("delay_busy_cycles", 32'(cnt), 32'(n));
    check_eq("ready_after_delay", 32'(host.cmd_ready), 32'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, r;
    host.cmd_valid = 1'b0; host.cmd_op = 2'd0; host.cmd_data = 16'h0000; host.cmd_bits = 4'h0;
    host.rsp_ready = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clkin);
    check_eq("rst_cmd_ready", 32'(host.cmd_ready), 32'd0);
    check_eq("rst_cs", 32'(cs), 32'd1);
    check_eq("rst_eng_go", 32'(eng_go), 32'd0);
    check_eq("rst_rsp_valid", 32'(host.rsp_valid), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_err_timeout", 32'(err_timeout), 32'd0);
    check_eq("rst_eng_autocs", 32'(eng_autocs), 32'd0);
    check_eq("rst_eng_data_i", 32'(eng_data_i), 32'd0);
    check_eq("rst_rsp_data", 32'(host.rsp_data), 32'd0);
    rst = 1'b0;
    @(negedge clkin);
    check_eq("idle_cmd_ready", 32'(host.cmd_ready), 32'd1);

    // Framed 16-bit loopback transfer
    send(OP_CS_LOW, 16'h0000, 4'h0);
    check_eq("cs_low", 32'(cs), 32'd0);
    check_eq("ready_after_cs", 32'(host.cmd_ready), 32'd1);
    do_xfer(16'hA5C3, 4'd15, 0, 0);
    send(OP_CS_HIGH, 16'h0000, 4'h0);
    check_eq("cs_high", 32'(cs), 32'd1);

    // 8-bit transfer with miso high, cs left high
    do_xfer(16'h00F0, 4'd7, 1, 0);

    // Response held off by the consumer
    do_xfer(16'h3C96, 4'd15, 0, 6);

    // Delays, including the zero-length no-op
    do_delay(5);
    do_delay(0);
    do_delay(0);

    // Reset in the middle of a transfer
    send(OP_CS_LOW, 16'h0000, 4'h0);
    eng_mode = 0; eng_lat = 0;
    send(OP_XFER, 16'h1357, 4'd15);
    w = 0;
    while (!eng_state && w < 50) begin
      @(negedge clkin); w++;
    end
    check_eq("engine_started", 32'(w < 50), 32'd1);
    @(negedge clkin);
    check_eq("busy_before_rst", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clkin);
    check_eq("midrst_cs", 32'(cs), 32'd1);
    check_eq("midrst_eng_go", 32'(eng_go), 32'd0);
    check_eq("midrst_rsp_valid", 32'(host.rsp_valid), 32'd0);
    check_eq("midrst_busy", 32'(busy), 32'd0);
    check_eq("midrst_cmd_ready", 32'(host.cmd_ready), 32'd0);
    repeat (2) @(negedge clkin);
    rst = 1'b0;
    exp_cs = 1'b1;
    @(negedge clkin);

    // Randomized command stream
    for (int k = 0; k < 40; k++) begin
      r = $urandom_range(0, 9);
      if (r == 0 || r == 1) begin
        send((r == 0) ? OP_CS_LOW : OP_CS_HIGH, 16'($urandom), 4'($urandom));
        check_eq("rand_cs", 32'(cs), 32'(exp_cs));
      end else if (r <= 6) begin
        do_xfer(16'($urandom), 4'($urandom), $urandom_range(0, 1), $urandom_range(0, 3));
      end else begin
        do_delay($urandom_range(0, 12));
      end
    end

`ifdef SEQ_TIMEOUT_EN
    // Engine never goes busy: abort after TIMEOUT_CYC cycles
    send(OP_CS_LOW, 16'h0000, 4'h0);
    eng_mode = 2;
    send(OP_XFER, 16'h1234, 4'd15);
    w = 0;
    while (busy && w < 300) begin
      w++; @(negedge clkin);
    end
    check_eq("timeout_busy_cycles", 32'(w), 32'(TIMEOUT_CYC));
    check_eq("timeout_flag", 32'(err_timeout), 32'd1);
    check_eq("timeout_cs", 32'(cs), 32'd1);
    check_eq("timeout_no_rsp", 32'(host.rsp_valid), 32'd0);
    exp_cs = 1'b1;
    do_xfer(16'hBEEF, 4'd11, 0, 0);
    check_eq("timeout_sticky", 32'(err_timeout), 32'd1);
`else
    check_eq("err_timeout_tied", 32'(err_timeout), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
